// File: rtl/pic_pkg.sv
// Shared constants and types for the pic8259_lite interrupt controller.
// Holds the RST opcode base, the OCW2 EOI codes and the read-select encoding.
package pic_pkg;

    localparam logic [7:0] RST_BASE     = 8'hC7;
    localparam logic [7:0] VEC_SPURIOUS = 8'hFF;

    localparam logic [2:0] EOI_NS = 3'b001;
    localparam logic [2:0] EOI_SP = 3'b011;

    typedef enum logic {
        RD_IRR = 1'b0,
        RD_ISR = 1'b1
    } rd_sel_e;

    // Opcode for RST n, n in 0..7.
    function automatic logic [7:0] rst_opcode(input logic [2:0] n);
        return RST_BASE | {2'b00, n, 3'b000};
    endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index-first priority encoder over an 8-bit request vector.
// Bit 0 has the highest priority; valid_o is low when no bit is set.
module pic_prio_enc (
    input  logic [7:0] req_i,
    output logic [2:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = 3'd0;
        valid_o = 1'b0;
        // Scan downwards so the lowest set bit is the last one to win.
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic8259_lite.sv
// Minimal 8259-style interrupt controller: request capture, masking, fully
// nested priority, RST n vector generation on INTA, and OCW2/OCW3 handling.
module pic8259_lite
    import pic_pkg::*;
#(
    parameter bit          EDGE_TRIG   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ce_i,
    input  logic       addr_i,
    input  logic [7:0] data_in_i,
    input  logic       we_i,
    input  logic       rd_i,
    output logic [7:0] data_out_o,
    input  logic [7:0] irq_i,
    input  logic       inta_ni,
    output logic       intr_o,
    output logic [7:0] vector_o
);

    localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [Stages-1:0][7:0] sync_q;
    logic [7:0]             irq_s;
    logic [7:0]             irq_prev_q;

    logic [7:0] imr_q, imr_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    rd_sel_e    rd_sel_q, rd_sel_d;
    logic [7:0] vector_q, vector_d;
    logic       intr_q, intr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       we_q;
    logic       inta_n_q;

    logic [7:0] pending;
    logic [2:0] pend_idx, isr_idx;
    logic       pend_valid, isr_valid;
    logic       wr_stb, ack;

    // Reads have no side effects, so the strobe is not needed for the data path.
    logic unused_rd;
    assign unused_rd = rd_i;

    assign irq_s   = sync_q[Stages-1];
    assign pending = irr_q & ~imr_q;
    assign wr_stb  = we_i & ~we_q;
    assign ack     = ~inta_ni & inta_n_q;

    pic_prio_enc u_pend_enc (
        .req_i   (pending),
        .idx_o   (pend_idx),
        .valid_o (pend_valid)
    );

    pic_prio_enc u_isr_enc (
        .req_i   (isr_q),
        .idx_o   (isr_idx),
        .valid_o (isr_valid)
    );

    always_comb begin
        irr_d    = irr_q;
        isr_d    = isr_q;
        imr_d    = imr_q;
        rd_sel_d = rd_sel_q;
        vector_d = vector_q;

        if (ack) begin
            if (pend_valid) begin
                vector_d          = rst_opcode(pend_idx);
                isr_d[pend_idx]   = 1'b1;
                if (EDGE_TRIG) begin
                    irr_d[pend_idx] = 1'b0;
                end
            end else begin
                vector_d = VEC_SPURIOUS;
            end
        end

        // A new edge on the bit being acknowledged wins over the clear.
        if (EDGE_TRIG) begin
            irr_d = irr_d | (irq_s & ~irq_prev_q);
        end else begin
            irr_d = irq_s;
        end

        if (wr_stb) begin
            if (addr_i) begin
                imr_d = data_in_i;
            end else if (data_in_i[4:3] == 2'b00) begin
                // EOI applies after any same-cycle INTA has set its ISR bit.
                if (data_in_i[7:5] == EOI_NS) begin
                    isr_d = isr_d & (isr_d - 8'd1);
                end else if (data_in_i[7:5] == EOI_SP) begin
                    isr_d[data_in_i[2:0]] = 1'b0;
                end
            end else if (data_in_i[4:3] == 2'b01 && data_in_i[1]) begin
                rd_sel_d = rd_sel_e'(data_in_i[0]);
            end
        end
    end

    // Fully nested: only a strictly higher-priority pending request interrupts.
    always_comb begin
        intr_d = inta_ni & pend_valid & (~isr_valid | (pend_idx < isr_idx));
    end

    always_comb begin
        if (addr_i) begin
            data_out_d = imr_q;
        end else if (rd_sel_q == RD_ISR) begin
            data_out_d = isr_q;
        end else begin
            data_out_d = irr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            irq_prev_q <= 8'h00;
            imr_q      <= 8'hFF;
            irr_q      <= 8'h00;
            isr_q      <= 8'h00;
            rd_sel_q   <= RD_IRR;
            vector_q   <= 8'h00;
            intr_q     <= 1'b0;
            we_q       <= 1'b0;
            inta_n_q   <= 1'b1;
        end else if (ce_i) begin
            sync_q     <= {sync_q[Stages-2:0], irq_i};
            irq_prev_q <= irq_s;
            imr_q      <= imr_d;
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            rd_sel_q   <= rd_sel_d;
            vector_q   <= vector_d;
            intr_q     <= intr_d;
            we_q       <= we_i;
            inta_n_q   <= inta_ni;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_out_q <= 8'h00;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out_o = data_out_q;
    assign intr_o     = intr_q;
    assign vector_o   = vector_q;

endmodule
